interrupt_seq: RTL
==================

INTERRUPT_SEQ -- requirements
Module: interrupt_seq

Interface
REQ-001 clk  in  1  core clock; rst  in  1  reset, synchronous, active-high.
REQ-002 ext_irq  in  1  external interrupt level; tmr_irq  in  1  timer interrupt level.
REQ-003 wfi_inst, mret_inst  in  1 each  WFI / MRET decoded, valid in EX for one cycle.
REQ-004 ex_pc  in  32  PC of EX instruction; resume_pc  in  32  PC of oldest uncommitted instruction.
REQ-005 IM_busy, DM_busy, Flush  in  1 each  fetch stall, data stall, branch redirect.
REQ-006 csr_we  in  1; csr_addr  in  12; csr_wdata  in  32; csr_rdata  out  32 (combinational read).
REQ-007 interrupt_taken, MRET, WFI_mode  out  1 each; mtvec_PC, mepc_PC  out  32  redirect targets for the next-PC mux.

Function
REQ-008 CSRs: mstatus 0x300 (MIE b3, MPIE b7, MPP b12:11 reads 2'b11, rest 0); mie 0x304 (MTIE b7, MEIE b11 writable, rest 0); mtvec 0x305 (b31:2 writable, b1:0 read 0); mepc 0x341 (b1:0 read 0); mcause 0x342; mip 0x344 read-only (MTIP b7 = tmr_irq, MEIP b11 = ext_irq).
REQ-009 Unmapped csr_addr reads 0; writes to it ignored.
REQ-010 pend = |(mip & mie); take = pend & mstatus.MIE.
REQ-011 FSM states RUN, TRAP, RET, WFI.
REQ-012 Sampling gate: take/pend evaluated only when IM_busy=0, DM_busy=0, Flush=0; otherwise deferred, no state change.
REQ-013 RUN->TRAP when take; takes priority over mret_inst and wfi_inst in the same cycle; mepc<=resume_pc.
REQ-014 RUN->RET on mret_inst (gated as REQ-012, no take).
REQ-015 RUN->WFI on wfi_inst (gated, no take); mepc<=ex_pc+4.
REQ-016 TRAP lasts exactly 1 cycle: interrupt_taken=1; mcause<=0x8000000B if MEIP&MEIE else 0x80000007 (external over timer); MPIE<=MIE; MIE<=0; ->RUN.
REQ-017 RET lasts exactly 1 cycle: MRET=1; MIE<=MPIE; MPIE<=1; ->RUN.
REQ-018 WFI: WFI_mode=1; stays until pend (ignores MIE and busy). pend&MIE -> TRAP (mepc keeps ex_pc+4). pend&~MIE -> RUN, no trap.
REQ-019 mtvec_PC = {mtvec[31:2],2'b00}; mepc_PC = {mepc[31:2],2'b00}; both always driven.
REQ-020 interrupt_taken and MRET never asserted together; each is a single-cycle pulse.
REQ-021 CSR software write in the same cycle as a hardware update to the same field: hardware update wins.
REQ-022 ex_pc+4 wraps modulo 2^32.

Reset
REQ-023 rst in any state (including mid-TRAP/WFI): state<=RUN next edge.
REQ-024 Reset values: mstatus MIE=0, MPIE=0; mie=0; mtvec=0; mepc=0; mcause=0; interrupt_taken=0; MRET=0; WFI_mode=0.

Configuration
REQ-025 Macro INTSEQ_TIMER_IRQ_EN: defined -> timer source and MTIE/MTIP behave per REQ-008.
REQ-026 Undefined -> tmr_irq ignored; MTIE and MTIP read 0; writes to MTIE have no effect; only cause 0x8000000B.

Verification
REQ-027 MIE=1, MEIE=1, ext_irq=1, resume_pc=0x100, mtvec=0x400 -> one-cycle interrupt_taken, mtvec_PC=0x400, mepc=0x100, mcause=0x8000000B, MIE=0, MPIE=1.
REQ-028 Same as REQ-027 with DM_busy=1 for 3 cycles -> interrupt_taken asserted on the first cycle after DM_busy falls, not earlier.
REQ-029 After REQ-027, mret_inst=1 -> MRET=1 for 1 cycle, mepc_PC=0x100, MIE=1, MPIE=1.
REQ-030 wfi_inst at ex_pc=0x200, MIE=0, MTIE=1, tmr_irq=1 after 5 cycles -> WFI_mode=1 for 5 cycles, back to RUN, no interrupt_taken; with MIE=1 -> TRAP, mepc=0x204, mcause=0x80000007.
REQ-031 ext_irq and tmr_irq both rise, both enabled -> mcause=0x8000000B; rst asserted while in WFI -> WFI_mode=0 next cycle, all CSRs at reset values.

Source files
------------

// File: rtl/interrupt_seq.sv
// Machine-mode interrupt sequencer: CSR file, trap entry/return and WFI sleep.
// Define INTSEQ_TIMER_IRQ_EN to enable the timer source (MTIE/MTIP); otherwise only external interrupts exist.
module interrupt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        tmr_irq,
    input  logic        wfi_inst,
    input  logic        mret_inst,
    input  logic [31:0] ex_pc,
    input  logic [31:0] resume_pc,
    input  logic        IM_busy,
    input  logic        DM_busy,
    input  logic        Flush,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        interrupt_taken,
    output logic        MRET,
    output logic        WFI_mode,
    output logic [31:0] mtvec_PC,
    output logic [31:0] mepc_PC
);

`ifdef INTSEQ_TIMER_IRQ_EN
    localparam logic TMR_EN = 1'b1;
`else
    localparam logic TMR_EN = 1'b0;
`endif

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_TRAP = 2'd1;
    localparam logic [1:0] S_RET  = 2'd2;
    localparam logic [1:0] S_WFI  = 2'd3;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

    logic [1:0]  state_q, state_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic        meie_q, meie_d, mtie_q, mtie_d;
    logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        mtip, pend, take, quiet;
    logic [31:0] wfi_ret_pc;

    assign mtip       = TMR_EN & tmr_irq;
    assign pend       = (ext_irq & meie_q) | (mtip & mtie_q);
    assign take       = pend & mie_q;
    assign quiet      = ~IM_busy & ~DM_busy & ~Flush;
    assign wfi_ret_pc = ex_pc + 32'd4;

    // Software writes are applied first so the FSM's hardware updates below override them.
    always_comb begin
        state_d  = state_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtie_d   = mtie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;

        if (csr_we) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                A_MIE: begin
                    meie_d = csr_wdata[11];
                    mtie_d = TMR_EN & csr_wdata[7];
                end
                A_MTVEC:  mtvec_d  = csr_wdata[31:2];
                A_MEPC:   mepc_d   = csr_wdata[31:2];
                A_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        case (state_q)
            S_RUN: begin
                if (quiet) begin
                    if (take) begin
                        state_d = S_TRAP;
                        mepc_d  = resume_pc[31:2];
                    end else if (mret_inst) begin
                        state_d = S_RET;
                    end else if (wfi_inst) begin
                        state_d = S_WFI;
                        mepc_d  = wfi_ret_pc[31:2];
                    end
                end
            end
            S_TRAP: begin
                mcause_d = (!TMR_EN || (ext_irq & meie_q)) ? CAUSE_EXT : CAUSE_TMR;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                state_d  = S_RUN;
            end
            S_RET: begin
                mie_d   = mpie_q;
                mpie_d  = 1'b1;
                state_d = S_RUN;
            end
            default: begin
                // Sleep wakes on any enabled pending source; MIE only decides whether it traps.
                if (pend) state_d = mie_q ? S_TRAP : S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS: csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            A_MIE:     csr_rdata = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
            A_MTVEC:   csr_rdata = {mtvec_q, 2'b00};
            A_MEPC:    csr_rdata = {mepc_q, 2'b00};
            A_MCAUSE:  csr_rdata = mcause_q;
            A_MIP:     csr_rdata = {20'd0, ext_irq, 3'd0, mtip, 7'd0};
            default:   csr_rdata = '0;
        endcase
    end

    assign interrupt_taken = (state_q == S_TRAP);
    assign MRET            = (state_q == S_RET);
    assign WFI_mode        = (state_q == S_WFI);
    assign mtvec_PC        = {mtvec_q, 2'b00};
    assign mepc_PC         = {mepc_q, 2'b00};

endmodule
